// File: rtl/encode_pack.sv
// rtl/encode_pack.sv - packs variable-length codes into DW-bit words with backpressure and flush
// Accumulator keeps its unused bits zero so a flushed word is already zero-padded.

module encode_pack #(
    parameter int DW        = 64,
    parameter int CW        = 13,
    parameter int LW        = 4,
    parameter int MSB_FIRST = 1,
    parameter int BW        = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          cnt_output_enable,
    input  logic [CW-1:0] cnt_output,
    input  logic [LW-1:0] cnt_len,
    input  logic          cnt_finish,
    output logic          cnt_ready,
    input  logic          fo_full,
    output logic [DW-1:0] m_dst,
    output logic          m_dst_putn,
    output logic          m_dst_last,
    output logic [BW-1:0] m_dst_vbits,
    output logic          m_endn
);

    localparam int SW = BW + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [BW-1:0] fill_q, fill_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] pend_word_q, pend_word_d;
    logic          pend_last_q, pend_last_d;
    logic [BW-1:0] pend_vbits_q, pend_vbits_d;
    logic [DW-1:0] dst_q, dst_d;
    logic          putn_q, putn_d;
    logic          last_q, last_d;
    logic [BW-1:0] vbits_q, vbits_d;
    logic          endn_q, endn_d;

    logic [LW-1:0]   len_eff;
    logic [CW-1:0]   code_mask;
    logic [BW-1:0]   sum;
    logic [SW-1:0]   shamt;
    logic [2*DW-1:0] code_ext;
    logic [2*DW-1:0] merged;
    logic [DW-1:0]   full_word;
    logic [DW-1:0]   resid;
    logic            complete;
    logic            accept_code;
    logic            accept_fin;
    logic            emit;

    assign cnt_ready = (state_q == ST_RUN) & ~pend_q;

    assign len_eff   = (cnt_len > LW'(CW)) ? LW'(CW) : cnt_len;
    assign code_mask = cnt_output & ~({CW{1'b1}} << len_eff);
    assign sum       = fill_q + BW'(len_eff);
    assign complete  = {1'b0, sum} >= SW'(DW);

    // MSB-first fills from the top of a 2*DW window; LSB-first fills from the bottom.
    always_comb begin
        shamt    = '0;
        code_ext = '0;
        merged   = '0;
        if (MSB_FIRST != 0) begin
            shamt     = SW'(2 * DW) - {1'b0, sum};
            code_ext  = {{(2*DW-CW){1'b0}}, code_mask} << shamt;
            merged    = {acc_q, {DW{1'b0}}} | code_ext;
            full_word = merged[2*DW-1:DW];
            resid     = merged[DW-1:0];
        end else begin
            shamt     = {1'b0, fill_q};
            code_ext  = {{(2*DW-CW){1'b0}}, code_mask} << shamt;
            merged    = {{DW{1'b0}}, acc_q} | code_ext;
            full_word = merged[DW-1:0];
            resid     = merged[2*DW-1:DW];
        end
    end

    assign accept_code = ce & cnt_ready & cnt_output_enable & (len_eff != '0);
    assign accept_fin  = ce & cnt_ready & cnt_finish;
    assign emit        = ce & pend_q & ~fo_full;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        pend_d       = pend_q;
        pend_word_d  = pend_word_q;
        pend_last_d  = pend_last_q;
        pend_vbits_d = pend_vbits_q;
        dst_d        = dst_q;
        putn_d       = 1'b1;
        last_d       = last_q;
        vbits_d      = vbits_q;
        endn_d       = 1'b1;

        if (emit) begin
            dst_d   = pend_word_q;
            putn_d  = 1'b0;
            last_d  = pend_last_q;
            vbits_d = pend_vbits_q;
            pend_d  = 1'b0;
        end

        if (accept_code) begin
            if (complete) begin
                pend_word_d  = full_word;
                pend_last_d  = 1'b0;
                pend_vbits_d = BW'(DW);
                pend_d       = 1'b1;
                acc_d        = resid;
                fill_d       = sum - BW'(DW);
            end else begin
                acc_d  = full_word;
                fill_d = sum;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (accept_fin) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // A word completed by the finishing code must drain before the remainder.
                if (ce & ~pend_q) begin
                    pend_word_d  = acc_q;
                    pend_last_d  = 1'b1;
                    pend_vbits_d = fill_q;
                    pend_d       = 1'b1;
                    state_d      = ST_END;
                end
            end
            ST_END: begin
                if (ce & ~pend_q) begin
                    endn_d  = 1'b0;
                    acc_d   = '0;
                    fill_d  = '0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            pend_q       <= 1'b0;
            pend_word_q  <= '0;
            pend_last_q  <= 1'b0;
            pend_vbits_q <= '0;
            dst_q        <= '0;
            putn_q       <= 1'b1;
            last_q       <= 1'b0;
            vbits_q      <= '0;
            endn_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            pend_q       <= pend_d;
            pend_word_q  <= pend_word_d;
            pend_last_q  <= pend_last_d;
            pend_vbits_q <= pend_vbits_d;
            dst_q        <= dst_d;
            putn_q       <= putn_d;
            last_q       <= last_d;
            vbits_q      <= vbits_d;
            endn_q       <= endn_d;
        end
    end

    assign m_dst       = dst_q;
    assign m_dst_putn  = putn_q;
    assign m_dst_last  = last_q;
    assign m_dst_vbits = vbits_q;
    assign m_endn      = endn_q;

endmodule
